// File: rtl/cache_pkg.sv
// cache_pkg: shared defaults, derived address-field widths and controller state encoding.
package cache_pkg;
    localparam int DEF_BLOCK_SIZE_BYTE = 16;
    localparam int DEF_NUM_LINES       = 64;
    localparam int DEF_ADDR_WIDTH      = 16;
    localparam int OFFSET_W = $clog2(DEF_BLOCK_SIZE_BYTE);
    localparam int INDEX_W  = $clog2(DEF_NUM_LINES);
    localparam int TAG_W    = DEF_ADDR_WIDTH - INDEX_W - OFFSET_W;
    typedef enum logic [1:0] {IDLE, LOOKUP, FETCH, RESPOND} state_e;
endpackage

// File: rtl/cache_line_store.sv
// cache_line_store: direct-mapped tag/valid/data arrays with one write port and a combinational read.
module cache_line_store import cache_pkg::*; #(
    parameter int NUM_LINES = DEF_NUM_LINES,
    parameter int TW        = TAG_W,
    parameter int LW        = DEF_BLOCK_SIZE_BYTE * 8,
    localparam int IW       = $clog2(NUM_LINES)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          we_i,
    input  logic [IW-1:0] widx_i,
    input  logic [TW-1:0] wtag_i,
    input  logic [LW-1:0] wdata_i,
    input  logic [IW-1:0] ridx_i,
    output logic          rvalid_o,
    output logic [TW-1:0] rtag_o,
    output logic [LW-1:0] rdata_o
);
    logic [NUM_LINES-1:0] valid_q;
    logic [TW-1:0]        tag_q  [NUM_LINES];
    logic [LW-1:0]        data_q [NUM_LINES];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) valid_q <= '0;
        else if (clr_i) valid_q <= '0;
        else if (we_i) valid_q[widx_i] <= 1'b1;

    // Contents stay unreset; the valid bits alone decide whether they mean anything.
    always_ff @(posedge clk)
        if (we_i) begin
            tag_q[widx_i]  <= wtag_i;
            data_q[widx_i] <= wdata_i;
        end

    assign rvalid_o = valid_q[ridx_i];
    assign rtag_o   = tag_q[ridx_i];
    assign rdata_o  = data_q[ridx_i];
endmodule

// File: rtl/cache_controller.sv
// cache_controller: direct-mapped read cache front end; looks up trace addresses, fetches missing
// lines through a start/block_ready handshake and returns one byte per request.
module cache_controller import cache_pkg::*; #(
    parameter int BLOCK_SIZE_BYTE = DEF_BLOCK_SIZE_BYTE,
    parameter int NUM_LINES       = DEF_NUM_LINES,
    parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
    localparam int OW = $clog2(BLOCK_SIZE_BYTE),
    localparam int IW = $clog2(NUM_LINES),
    localparam int TW = ADDR_WIDTH - IW - OW
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         trace_valid,
    input  logic [ADDR_WIDTH-1:0]        trace_addr,
    output logic                         trace_ready,
    input  logic                         flush,
    output logic                         start,
    output logic [TW-1:0]                fetch_tag,
    output logic [IW-1:0]                fetch_index,
    input  logic [BLOCK_SIZE_BYTE*8-1:0] block,
    input  logic                         block_ready,
    output logic                         resp_valid,
    output logic                         resp_hit,
    output logic [7:0]                   resp_data,
    output logic [15:0]                  hit_count,
    output logic [15:0]                  miss_count
);
    state_e                      state_q, state_d;
    logic [ADDR_WIDTH-1:0]       addr_q;
    logic                        hit_q, br_q;
    logic [15:0]                 hit_count_q, miss_count_q;
    logic                        line_valid, hit, fill;
    logic [TW-1:0]               line_tag;
    logic [BLOCK_SIZE_BYTE*8-1:0] line_data;
    logic [OW-1:0]               off;

    // The latched address doubles as the fetch request, so it is stable from start to fill.
    assign {fetch_tag, fetch_index, off} = addr_q;
    assign hit  = line_valid && line_tag == fetch_tag;
    assign fill = state_q == FETCH && block_ready && !br_q;
    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

    cache_line_store #(.NUM_LINES(NUM_LINES), .TW(TW), .LW(BLOCK_SIZE_BYTE*8)) u_store (
        .clk(clk), .rst_n(rst_n), .clr_i(state_q == IDLE && flush), .we_i(fill),
        .widx_i(fetch_index), .wtag_i(fetch_tag), .wdata_i(block), .ridx_i(fetch_index),
        .rvalid_o(line_valid), .rtag_o(line_tag), .rdata_o(line_data)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state_q <= IDLE;
        else state_q <= state_d;

    always_comb
        case (state_q)
            IDLE:    state_d = trace_valid && trace_ready ? LOOKUP : IDLE;
            LOOKUP:  state_d = hit ? RESPOND : FETCH;
            FETCH:   state_d = fill ? RESPOND : FETCH;
            default: state_d = IDLE;
        endcase

    always_comb begin
        trace_ready = state_q == IDLE && !flush;
        start       = state_q == LOOKUP && !hit;
        resp_valid  = state_q == RESPOND;
        resp_hit    = resp_valid && hit_q;
        resp_data   = resp_valid ? line_data[{off, 3'b000} +: 8] : 8'h00;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            addr_q       <= '0;
            hit_q        <= 1'b0;
            br_q         <= 1'b0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            br_q <= block_ready;
            if (trace_valid && trace_ready) addr_q <= trace_addr;
            if (state_q == LOOKUP) hit_q <= hit;
            if (state_q == LOOKUP && hit && hit_count_q != 16'hFFFF) hit_count_q <= hit_count_q + 16'd1;
            if (start && miss_count_q != 16'hFFFF) miss_count_q <= miss_count_q + 16'd1;
        end
endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: randomized scenarios checked against an array-based model of a direct-mapped cache.
module tb_cache_controller;
    logic         clk = 0, rst_n = 0, trace_valid = 0, flush = 0, block_ready = 0;
    logic [15:0]  trace_addr = '0;
    logic [127:0] block = '0;
    logic         trace_ready, start, resp_valid, resp_hit;
    logic [5:0]   fetch_tag, fetch_index;
    logic [7:0]   resp_data;
    logic [15:0]  hit_count, miss_count;
    int checks = 0, failures = 0;
    logic         mv [64];
    logic [5:0]   mt [64];
    logic [127:0] md [64];
    int m_hit = 0, m_miss = 0;
    logic [127:0] ramp;

    cache_controller dut (
        .clk(clk), .rst_n(rst_n), .trace_valid(trace_valid), .trace_addr(trace_addr),
        .trace_ready(trace_ready), .flush(flush), .start(start), .fetch_tag(fetch_tag),
        .fetch_index(fetch_index), .block(block), .block_ready(block_ready),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_data(resp_data),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] rand_block();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) mv[i] = 1'b0;
        m_hit = 0;
        m_miss = 0;
    endtask

    // One request: predicts hit/miss from the model, plays the fetcher on a miss, checks the response.
    task automatic do_access(input logic [15:0] a, input logic [127:0] blk, input int lat, input int hold);
        int idx, off;
        logic [5:0] tg;
        logic eh;
        logic [7:0] ed;
        idx = int'(a[9:4]);
        off = int'(a[3:0]);
        tg = a[15:10];
        eh = mv[idx] && mt[idx] == tg;
        @(negedge clk);
        checks++; if (trace_ready !== 1'b1) begin failures++; $display("FAIL ready_idle addr=%h: got %b expected 1", a, trace_ready); end
        trace_valid = 1'b1;
        trace_addr = a;
        @(negedge clk);
        trace_valid = 1'b0;
        checks++; if (start !== !eh) begin failures++; $display("FAIL start_lookup addr=%h: got %b expected %b", a, start, !eh); end
        if (!eh) begin
            checks++; if (fetch_index !== 6'(idx)) begin failures++; $display("FAIL fetch_index addr=%h: got %h expected %h", a, fetch_index, 6'(idx)); end
            checks++; if (fetch_tag !== tg) begin failures++; $display("FAIL fetch_tag addr=%h: got %h expected %h", a, fetch_tag, tg); end
            for (int i = 0; i < lat; i++) begin
                @(negedge clk);
                checks++; if (resp_valid !== 1'b0 || start !== 1'b0 || fetch_tag !== tg) begin failures++; $display("FAIL fetch_wait addr=%h: got rv=%b st=%b tag=%h expected 0 0 %h", a, resp_valid, start, fetch_tag, tg); end
            end
            @(negedge clk);
            block = blk;
            block_ready = 1'b1;
            mv[idx] = 1'b1;
            mt[idx] = tg;
            md[idx] = blk;
            m_miss = m_miss < 65535 ? m_miss + 1 : 65535;
        end else m_hit = m_hit < 65535 ? m_hit + 1 : 65535;
        ed = md[idx][off*8 +: 8];
        @(negedge clk);
        checks++; if ({resp_valid, resp_hit, resp_data} !== {1'b1, eh, ed}) begin failures++; $display("FAIL response addr=%h: got v=%b h=%b d=%h expected v=1 h=%b d=%h", a, resp_valid, resp_hit, resp_data, eh, ed); end
        if (hold <= 1) block_ready = 1'b0;
        @(negedge clk);
        block_ready = 1'b0;
        checks++; if (resp_valid !== 1'b0 || start !== 1'b0) begin failures++; $display("FAIL single_resp addr=%h: got rv=%b st=%b expected 0 0", a, resp_valid, start); end
        checks++; if (hit_count !== 16'(m_hit) || miss_count !== 16'(m_miss)) begin failures++; $display("FAIL counters addr=%h: got %0d/%0d expected %0d/%0d", a, hit_count, miss_count, m_hit, m_miss); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #12;
        checks++; if ({start, resp_valid, resp_hit} !== 3'b000) begin failures++; $display("FAIL reset_strobes: got %b expected 000", {start, resp_valid, resp_hit}); end
        checks++; if (resp_data !== 8'h00) begin failures++; $display("FAIL reset_data: got %h expected 00", resp_data); end
        checks++; if ({fetch_tag, fetch_index} !== 12'h000) begin failures++; $display("FAIL reset_fetch: got %h expected 000", {fetch_tag, fetch_index}); end
        checks++; if (hit_count !== 16'h0 || miss_count !== 16'h0) begin failures++; $display("FAIL reset_counters: got %h/%h expected 0/0", hit_count, miss_count); end
        checks++; if (trace_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", trace_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_cold_miss();
        for (int k = 0; k < 16; k++) ramp[k*8 +: 8] = 8'(k);
        do_access(16'h0123, ramp, 2, 1);
        checks++; if (miss_count !== 16'd1 || hit_count !== 16'd0) begin failures++; $display("FAIL cold_miss_count: got %0d/%0d expected 0/1", hit_count, miss_count); end
        checks++; if (md[18][31:24] !== 8'h03) begin failures++; $display("FAIL cold_miss_byte: got %h expected 03", md[18][31:24]); end
    endtask

    task automatic test_hit();
        do_access(16'h012A, rand_block(), 0, 1);
        checks++; if (hit_count !== 16'd1 || miss_count !== 16'd1) begin failures++; $display("FAIL hit_count: got %0d/%0d expected 1/1", hit_count, miss_count); end
    endtask

    task automatic test_conflict();
        do_access(16'h4123, rand_block(), 1, 1);
        do_access(16'h0123, ramp, 0, 1);
        checks++; if (miss_count !== 16'd3) begin failures++; $display("FAIL conflict_misses: got %0d expected 3", miss_count); end
    endtask

    task automatic test_flush();
        @(negedge clk);
        flush = 1'b1;
        trace_valid = 1'b1;
        trace_addr = 16'h0123;
        @(negedge clk);
        checks++; if (trace_ready !== 1'b0) begin failures++; $display("FAIL flush_ready: got %b expected 0", trace_ready); end
        flush = 1'b0;
        trace_valid = 1'b0;
        @(negedge clk);
        checks++; if (trace_ready !== 1'b1 || start !== 1'b0) begin failures++; $display("FAIL flush_no_accept: got rdy=%b st=%b expected 1 0", trace_ready, start); end
        for (int i = 0; i < 64; i++) mv[i] = 1'b0;
        do_access(16'h0123, rand_block(), 1, 2);
        checks++; if (miss_count !== 16'd4) begin failures++; $display("FAIL flush_miss: got %0d expected 4", miss_count); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++)
            do_access({6'($urandom_range(0, 3)), 6'($urandom_range(16, 19)), 4'($urandom)},
                      rand_block(), int'($urandom_range(0, 3)), int'($urandom_range(1, 2)));
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 6; n++) do_access({12'h012, 4'(n)}, rand_block(), 0, 1);
    endtask

    task automatic test_reset_fetch();
        @(negedge clk);
        trace_valid = 1'b1;
        trace_addr = 16'h0555;
        @(negedge clk);
        trace_valid = 1'b0;
        checks++; if (start !== 1'b1) begin failures++; $display("FAIL rst_fetch_start: got %b expected 1", start); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if ({start, resp_valid, hit_count, miss_count} !== 34'h0) begin failures++; $display("FAIL rst_fetch_clear: got st=%b rv=%b %0d/%0d expected 0", start, resp_valid, hit_count, miss_count); end
        checks++; if ({fetch_tag, fetch_index} !== 12'h000) begin failures++; $display("FAIL rst_fetch_addr: got %h expected 000", {fetch_tag, fetch_index}); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        block = rand_block();
        block_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 1) block_ready = 1'b0;
            checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL rst_fetch_no_resp: got %b expected 0", resp_valid); end
        end
        do_access(16'h0555, rand_block(), 0, 1);
        do_access(16'h0123, ramp, 1, 1);
    endtask

    task automatic test_saturation();
        do_access(16'h0123, ramp, 0, 1);
        @(negedge clk);
        force dut.hit_count_q = 16'hFFFD;
        #1;
        release dut.hit_count_q;
        m_hit = 65533;
        for (int n = 0; n < 4; n++) do_access({12'h012, 4'($urandom)}, rand_block(), 0, 1);
        checks++; if (hit_count !== 16'hFFFF) begin failures++; $display("FAIL saturation: got %h expected ffff", hit_count); end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_flush();
        test_random();
        test_back_to_back();
        test_reset_fetch();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
